// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one asynchronous read port.
// Write lands on the clock edge; the read port is purely combinational, with no flow control of its own.
module fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through, threshold flags and sticky errors.
// Read latency is 1 cycle (FWFT=0) or 0 cycles (FWFT=1); a write when full or a read when empty is dropped and flagged.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_W-1:0]             data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [clog2_cnt(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = clog2_cnt(DEPTH);

  if (DATA_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AE_THRESH <= 0 || AF_THRESH <= AE_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
    $error("sync_fifo_param: illegal DATA_W/DEPTH/threshold parameters");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d, mem_rd;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, rd_acc;
  fifo_status_t      status;

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd)
  );

  always_comb begin
    status              = '0;
    status.full         = (count_q == CNT_W'(DEPTH));
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    status.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    status.overflow     = ovf_q;
    status.underflow    = udf_q;
  end

  assign wr_acc = wr_en && !status.full;
  assign rd_acc = rd_en && !status.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem_rd;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A fresh error event in the same cycle as clr_err must survive the clear.
    ovf_d = (wr_en && status.full)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    udf_d = (rd_en && status.empty) ? 1'b1 : (clr_err ? 1'b0 : udf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // In FWFT mode the unreset array is masked while empty so the output is never unknown.
  assign data_out     = (FWFT != 0) ? (status.empty ? '0 : mem_rd) : dout_q;
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a registered-read and a FWFT instance with identical stimulus and checks both against a queue model.
module tb_sync_fifo_param;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, rst, wr_en, rd_en, clr_err;
  logic [DW-1:0] data_in;
  logic [DW-1:0] dout0, dout1;
  logic [CW-1:0] count0, count1;
  logic          full0, empty0, af0, ae0, ovf0, udf0;
  logic          full1, empty1, af1, ae1, ovf1, udf1;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: contents as a queue, plus the registered-read output and sticky flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] dout_m;
  logic          ovf_m, udf_m;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count0"}, 64'(count0), 64'(n));
    chk({tag, ".full0"},  64'(full0),  64'(n == DEPTH));
    chk({tag, ".empty0"}, 64'(empty0), 64'(n == 0));
    chk({tag, ".af0"},    64'(af0),    64'(n >= AF));
    chk({tag, ".ae0"},    64'(ae0),    64'(n <= AE));
    chk({tag, ".ovf0"},   64'(ovf0),   64'(ovf_m));
    chk({tag, ".udf0"},   64'(udf0),   64'(udf_m));
    chk({tag, ".dout0"},  64'(dout0),  64'(dout_m));
    chk({tag, ".count1"}, 64'(count1), 64'(n));
    chk({tag, ".flags1"}, 64'({full1, empty1, af1, ae1, ovf1, udf1}),
        64'({n == DEPTH, n == 0, n >= AF, n <= AE, ovf_m, udf_m}));
    if (n > 0) chk({tag, ".dout1"}, 64'(dout1), 64'(mq[0]));
  endtask

  // One clock: drive inputs, update model from pre-edge occupancy, check 1ns after the edge.
  task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d,
                       input logic r, input logic c);
    bit f, e;
    wr_en = w; data_in = d; rd_en = r; clr_err = c;
    @(posedge clk);
    f = (mq.size() == DEPTH);
    e = (mq.size() == 0);
    ovf_m = (w && f) ? 1'b1 : (c ? 1'b0 : ovf_m);
    udf_m = (r && e) ? 1'b1 : (c ? 1'b0 : udf_m);
    if (r && !e) dout_m = mq.pop_front();
    if (w && !f) mq.push_back(d);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    dout_m = '0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.dout1", 64'(dout1), 64'd0);
    @(negedge clk) rst = 1'b0;

    // Idle after reset, then reset asynchronously in the middle of a burst at count=5.
    cycle("idle", 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("burst", 1'b1, $urandom, 1'b0, 1'b0);
    chk("burst.count5", 64'(count0), 64'd5);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("midrst");
    @(negedge clk) rst = 1'b0;

    // Fill 0x1..0x10, overflow on a 17th write, clear it.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle("fill", 1'b1, DW'(i), 1'b0, 1'b0);
      if (i == AF) chk("fill.af_at_14", 64'(af0), 64'd1);
    end
    chk("fill.full", 64'(full0), 64'd1);
    cycle("ovf", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("ovf.set", 64'(ovf0), 64'd1);
    cycle("clr", 1'b0, '0, 1'b0, 1'b1);
    chk("ovf.clr", 64'(ovf0), 64'd0);

    // Drain in order, then an extra read underflows and leaves data_out at 0x10.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle("drain", 1'b0, '0, 1'b1, 1'b0);
      chk("drain.order", 64'(dout0), 64'(i));
    end
    cycle("udf", 1'b0, '0, 1'b1, 1'b0);
    chk("udf.set", 64'(udf0), 64'd1);
    chk("udf.hold", 64'(dout0), 64'h10);
    // Set event coincides with clr_err: set must win.
    cycle("udf_vs_clr", 1'b0, '0, 1'b1, 1'b1);
    chk("udf.setwins", 64'(udf0), 64'd1);
    cycle("clr2", 1'b0, '0, 1'b0, 1'b1);

    // FWFT fall-through of a single word, then pop.
    cycle("fwft_wr", 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    chk("fwft.show", 64'(dout1), 64'hA5A5_A5A5);
    cycle("fwft_pop", 1'b0, '0, 1'b1, 1'b0);
    chk("fwft.empty", 64'(empty1), 64'd1);

    // Fill to 8 and stream 40 simultaneous read/write cycles across the pointer wrap.
    for (int i = 0; i < 8; i++) cycle("to8", 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle("stream", 1'b1, $urandom, 1'b1, 1'b0);
    chk("stream.count8", 64'(count0), 64'd8);

    // Full with both requests: read wins; empty with both: write wins.
    for (int i = 0; i < 8; i++) cycle("tofull", 1'b1, $urandom, 1'b0, 1'b0);
    cycle("full_both", 1'b1, $urandom, 1'b1, 1'b0);
    chk("full_both.count", 64'(count0), 64'd15);
    chk("full_both.ovf", 64'(ovf0), 64'd1);
    for (int i = 0; i < 15; i++) cycle("toempty", 1'b0, '0, 1'b1, 1'b0);
    cycle("empty_both", 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    chk("empty_both.count", 64'(count0), 64'd1);
    chk("empty_both.udf", 64'(udf0), 64'd1);

    // Randomised traffic, with occasional error clears.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next-generation replacement for the fixed 32-bit FIFO `top`. It generalises data width and depth and adds an optional first-word-fall-through read mode. It also adds programmable almost-full/almost-empty flags, an occupancy count, and sticky overflow/underflow error flags. It sits between any producer/consumer pair in the same clock domain and is a drop-in for `top` at default parameters, provided the new outputs are left open and `clr_err` is tied 0.

## Interface
- `DATA_W`, default 32: data word width, ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥2.
- `AF_THRESH`, default DEPTH-2: `almost_full` asserted when count ≥ AF_THRESH.
- `AE_THRESH`, default 2: `almost_empty` asserted when count ≤ AE_THRESH.
- `FWFT`, default 0: 0 = standard registered read; 1 = first-word-fall-through.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `wr_en`  in  1: write request.
- `data_in`  in  DATA_W: write data.
- `rd_en`  in  1: read request (pop).
- `clr_err`  in  1: clears `overflow`/`underflow`.
- `data_out`  out  DATA_W: read data.
- `full`, `empty`  out  1: occupancy flags.
- `almost_full`, `almost_empty`  out  1: threshold flags.
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`, `underflow`  out  1: sticky error flags.

## Operation
- A write is accepted iff `wr_en && !full`. The word is stored at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- A read is accepted iff `rd_en && !empty`. `rd_ptr` increments modulo DEPTH.
- Acceptance uses the flags as they stand at the current edge. When full with both requests, the read is accepted and the write is rejected. When empty with both, the write is accepted and the read is rejected.
- `count` changes by +1 (write only), −1 (read only), or 0 (both accepted or neither).
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from `count`, not from pointer comparison.
- Flag definitions:
  - `full` = (count==DEPTH)
  - `empty` = (count==0)
  - `almost_full` = (count≥AF_THRESH)
  - `almost_empty` = (count≤AE_THRESH)
- FWFT=0: `data_out` is a register loaded with mem[rd_ptr] on an accepted read. It holds its value otherwise, including on rejected reads.
- FWFT=1: `data_out` = mem[rd_ptr] combinationally and is valid whenever `!empty`. Its value is don't-care when empty, but it must not be X after reset. An accepted read advances to the next word.
- `overflow` sets on `wr_en && full`. `underflow` sets on `rd_en && empty`. Both hold until `clr_err`. If a set event and `clr_err` occur in the same cycle, set wins.
- Reset values:
  - `count`=0, pointers=0, `empty`=1, `almost_empty`=1
  - `full`=0, `almost_full`=0, `data_out`=0, `overflow`=0, `underflow`=0
- Storage array is not reset. Reset mid-operation discards all contents immediately (asynchronously).

## Timing
- Write → visible: the `count`/flag update takes effect on the accepting edge. For FWFT=1, `data_out` shows the first word in the cycle after the write edge into an empty FIFO.
- FWFT=0 read latency: 1 cycle. `data_out` updates on the same edge that accepts `rd_en`.
- All flags and `count` are registered-state-derived. There are no combinational paths from `wr_en`/`rd_en` to any output.
- Throughput: one write and one read per cycle sustained.
- Reset deassertion: the first write is accepted on the first rising edge after `rst` falls.

## Structure
- Package `fifo_pkg`:
  - `typedef struct packed {full, empty, almost_full, almost_empty, overflow, underflow} fifo_status_t`
  - `localparam` default widths/depth
  - function `clog2_cnt(depth)` returning the `count` width
- Sub-module `fifo_mem`: a DEPTH×DATA_W register array with one synchronous write port and one asynchronous read port. The top level holds pointers, count, flags, error logic and the FWFT mux.
- Parameter legality (power-of-two DEPTH, 0<AE_THRESH<AF_THRESH≤DEPTH) is checked by elaboration-time assertions.

## Test plan
- Reset then idle → `empty`=1, `almost_empty`=1, `count`=0, `data_out`=0; assert `rst` mid-burst at count=5 → immediately `count`=0, `empty`=1.
- Write 16 words 0x1..0x10 (DEPTH=16) → `almost_full` at count=14, `full` at 16; a 17th write is rejected and sets `overflow`=1; pulse `clr_err` → 0.
- Drain the full FIFO with FWFT=0 → `data_out` = 0x1..0x10 in order, each one cycle after `rd_en`; extra read → `underflow`=1, `data_out` holds 0x10.
- FWFT=1: write 0xA5A5A5A5 into an empty FIFO → `data_out`=0xA5A5A5A5 the next cycle with no `rd_en`; pop → `empty`=1.
- Simultaneous `wr_en`/`rd_en` for 40 cycles at count=8 → `count` stays 8, data order preserved across pointer wrap.
- Full with both requests → read accepted, write rejected, `count`=15, `overflow`=1; empty with both → `count`=1, `underflow`=1.
